hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 137 +++++++++++++
 tb/tb_hazard_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller.
// Produces stall, bubble and flush controls for the memory-wait,
// redirect-flush and load-use hazards, in that priority order.
// It also keeps a saturating stall-cycle counter and a wrapping flush counter.
module hazard_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_reg_write,
  input  logic        i_ex_redirect,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ready,
  output logic        o_stall_front,
  output logic        o_stall_back,
  output logic        o_bubble_id_ex,
  output logic        o_flush_if_id,
  output logic [15:0] o_stall_cycles,
  output logic [7:0]  o_flush_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  logic        mem_wait_s;
  logic        rs1_hit_s;
  logic        rs2_hit_s;
  logic        load_use_s;
  logic        do_flush_s;

  // Hazard detection terms.
  // A redirect that arrives during a memory wait is deferred via pending_q.
  always_comb begin
    mem_wait_s = i_dmem_req & ~i_dmem_ready;
    rs1_hit_s  = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    rs2_hit_s  = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    load_use_s = i_ex_mem_read & i_ex_reg_write & (i_ex_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);
    do_flush_s = ~mem_wait_s & (i_ex_redirect | pending_q);
  end

  // Control outputs.
  // Priority order is reset, then mem_wait, then flush, then load-use.
  always_comb begin
    o_stall_front  = 1'b0;
    o_stall_back   = 1'b0;
    o_bubble_id_ex = 1'b0;
    o_flush_if_id  = 1'b0;
    if (i_rst) begin
      o_stall_front  = 1'b0;
      o_stall_back   = 1'b0;
      o_bubble_id_ex = 1'b0;
      o_flush_if_id  = 1'b0;
    end else if (mem_wait_s) begin
      o_stall_front  = 1'b1;
      o_stall_back   = 1'b1;
    end else if (do_flush_s) begin
      // The flush squashes the dependent instruction, so any load-use is moot.
      o_flush_if_id  = 1'b1;
      o_bubble_id_ex = 1'b1;
    end else if (load_use_s) begin
      o_stall_front  = 1'b1;
      o_bubble_id_ex = 1'b1;
    end else begin
      o_stall_front  = 1'b0;
      o_stall_back   = 1'b0;
      o_bubble_id_ex = 1'b0;
      o_flush_if_id  = 1'b0;
    end
  end

  // Next-state logic: wait-state tracking, deferred redirect, and counters.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      RUN:      state_d = mem_wait_s ? MEM_WAIT : RUN;
      MEM_WAIT: state_d = mem_wait_s ? MEM_WAIT : RUN;
      default:  state_d = RUN;
    endcase

    // A redirect seen while pending is already set merges into the same flush.
    if (do_flush_s) begin
      pending_d = 1'b0;
    end else if (i_ex_redirect & mem_wait_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if (o_stall_front && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    if (do_flush_s) begin
      flush_cnt_d = flush_cnt_q + 8'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State register with synchronous reset.
  // Reset discards any deferred redirect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RUN;
      pending_q   <= 1'b0;
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cycles = stall_cnt_q;
  assign o_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: self-checking bench for hazard_unit.
// It runs directed scenarios and a randomized run checked against a reference model.
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        uses_rs1, uses_rs2, mem_read, reg_write, redirect, dmem_req, dmem_ready;
  logic        stall_front, stall_back, bubble, flush;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  int checks   = 0;
  int failures = 0;

  hazard_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_uses_rs1  (uses_rs1),
    .i_id_uses_rs2  (uses_rs2),
    .i_ex_rd        (ex_rd),
    .i_ex_mem_read  (mem_read),
    .i_ex_reg_write (reg_write),
    .i_ex_redirect  (redirect),
    .i_dmem_req     (dmem_req),
    .i_dmem_ready   (dmem_ready),
    .o_stall_front  (stall_front),
    .o_stall_back   (stall_back),
    .o_bubble_id_ex (bubble),
    .o_flush_if_id  (flush),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; mem_read = 1'b0; reg_write = 1'b0;
    redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Control bits are packed as {stall_front, stall_back, bubble, flush}.
  task automatic test_reset();
    rst = 1'b1;
    dmem_req = 1'b1; dmem_ready = 1'b0; redirect = 1'b1;
    mem_read = 1'b1; reg_write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; uses_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {stall_front, stall_back, bubble, flush});
    end
    tick();
    checks++;
    if ({stall_cycles, flush_count} !== 24'h0) begin
      failures++; $display("FAIL reset_counters: got %h/%h expected 0000/00", stall_cycles, flush_count);
    end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000) begin
      failures++; $display("FAIL reset_release_ctrl: got %b expected 0000", {stall_front, stall_back, bubble, flush});
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_rd = 5'd5; mem_read = 1'b1; reg_write = 1'b1; id_rs2 = 5'd5; uses_rs2 = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b1010) begin
      failures++; $display("FAIL load_use_ctrl: got %b expected 1010", {stall_front, stall_back, bubble, flush});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({stall_front, bubble} !== 2'b00) begin
      failures++; $display("FAIL load_use_release: got %b expected 00", {stall_front, bubble});
    end
    checks++;
    if (stall_cycles !== 16'd1) begin
      failures++; $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
    end
    // A matching instruction in EX that does not write the register file is not a hazard.
    ex_rd = 5'd7; mem_read = 1'b1; reg_write = 1'b0; id_rs1 = 5'd7; uses_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_front, bubble} !== 2'b00) begin
      failures++; $display("FAIL load_no_write: got %b expected 00", {stall_front, bubble});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    do_reset();
    ex_rd = 5'd0; id_rs1 = 5'd0; uses_rs1 = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000) begin
      failures++; $display("FAIL rd_zero: got %b expected 0000", {stall_front, stall_back, bubble, flush});
    end
    // A matching index whose use flag is clear is also not a hazard.
    ex_rd = 5'd9; id_rs1 = 5'd9; uses_rs1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall_front, bubble} !== 2'b00) begin
      failures++; $display("FAIL unused_rs1: got %b expected 00", {stall_front, bubble});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({stall_front, stall_back, bubble, flush} !== 4'b1100) begin
        failures++; $display("FAIL mem_wait_c%0d: got %b expected 1100", c, {stall_front, stall_back, bubble, flush});
      end
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_front, stall_back} !== 2'b00) begin
      failures++; $display("FAIL mem_wait_done: got %b expected 00", {stall_front, stall_back});
    end
    tick();
    idle_inputs();
    checks++;
    if (stall_cycles !== 16'd3) begin
      failures++; $display("FAIL mem_wait_count: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_redirect_in_wait();
    do_reset();
    // First wait: one redirect in the 2nd cycle. Second wait: redirects in the 1st and 3rd cycles.
    for (int w = 0; w < 2; w++) begin
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        redirect = (w == 0) ? (c == 1) : (c != 1);
        @(negedge clk);
        checks++;
        if ({bubble, flush} !== 2'b00) begin
          failures++; $display("FAIL redir_wait_w%0d_c%0d: got %b expected 00", w, c, {bubble, flush});
        end
        tick();
      end
      redirect = 1'b0; dmem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({stall_front, stall_back, bubble, flush} !== 4'b0011) begin
        failures++; $display("FAIL redir_flush_w%0d: got %b expected 0011", w, {stall_front, stall_back, bubble, flush});
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bubble, flush} !== 2'b00) begin
        failures++; $display("FAIL redir_single_w%0d: got %b expected 00", w, {bubble, flush});
      end
      checks++;
      if (flush_count !== 8'(w + 1)) begin
        failures++; $display("FAIL redir_count_w%0d: got %0d expected %0d", w, flush_count, w + 1);
      end
      tick();
    end
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    redirect = 1'b1; ex_rd = 5'd4; mem_read = 1'b1; reg_write = 1'b1; id_rs1 = 5'd4; uses_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0011) begin
      failures++; $display("FAIL redir_lu_ctrl: got %b expected 0011", {stall_front, stall_back, bubble, flush});
    end
    tick();
    idle_inputs();
    checks++;
    if ({stall_cycles, flush_count} !== {16'd0, 8'd1}) begin
      failures++; $display("FAIL redir_lu_counts: got %0d/%0d expected 0/1", stall_cycles, flush_count);
    end
  endtask

  task automatic test_random();
    bit m_pending;
    int m_stall, m_flush;
    bit mw, lu, df;
    logic [3:0] exp;
    do_reset();
    m_pending = 1'b0; m_stall = 0; m_flush = 0;
    for (int n = 0; n < 2000; n++) begin
      rst        = ($urandom_range(63) == 0);
      id_rs1     = 5'($urandom_range(3));
      id_rs2     = 5'($urandom_range(3));
      ex_rd      = 5'($urandom_range(3));
      uses_rs1   = 1'($urandom_range(1));
      uses_rs2   = 1'($urandom_range(1));
      mem_read   = 1'($urandom_range(1));
      reg_write  = 1'($urandom_range(1));
      redirect   = ($urandom_range(5) == 0);
      dmem_req   = ($urandom_range(2) == 0);
      dmem_ready = ($urandom_range(1) == 0);
      mw = dmem_req && !dmem_ready;
      lu = mem_read && reg_write && ex_rd != 0 &&
           ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd));
      df = !mw && (redirect || m_pending);
      if (rst)     exp = 4'b0000;
      else if (mw) exp = 4'b1100;
      else if (df) exp = 4'b0011;
      else if (lu) exp = 4'b1010;
      else         exp = 4'b0000;
      @(negedge clk);
      checks++;
      if ({stall_front, stall_back, bubble, flush} !== exp) begin
        failures++; $display("FAIL rand_ctrl_%0d: got %b expected %b", n, {stall_front, stall_back, bubble, flush}, exp);
      end
      if (rst) begin
        m_pending = 1'b0; m_stall = 0; m_flush = 0;
      end else begin
        if (exp[3]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (df) m_flush = (m_flush + 1) % 256;
        if (df) m_pending = 1'b0;
        else if (redirect && mw) m_pending = 1'b1;
      end
      tick();
      checks++;
      if (stall_cycles !== 16'(m_stall) || flush_count !== 8'(m_flush)) begin
        failures++; $display("FAIL rand_counts_%0d: got %0d/%0d expected %0d/%0d", n, stall_cycles, flush_count, m_stall, m_flush);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_stall_saturation();
    do_reset();
    ex_rd = 5'd12; mem_read = 1'b1; reg_write = 1'b1; id_rs1 = 5'd12; uses_rs1 = 1'b1;
    repeat (65534) tick();
    checks++;
    if (stall_cycles !== 16'hFFFE) begin
      failures++; $display("FAIL stall_sat_pre: got %h expected fffe", stall_cycles);
    end
    tick();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      failures++; $display("FAIL stall_sat_reach: got %h expected ffff", stall_cycles);
    end
    repeat (70000 - 65535) tick();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      failures++; $display("FAIL stall_sat_hold: got %h expected ffff", stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_flush_wrap();
    do_reset();
    redirect = 1'b1;
    repeat (255) tick();
    checks++;
    if (flush_count !== 8'hFF) begin
      failures++; $display("FAIL flush_wrap_pre: got %h expected ff", flush_count);
    end
    tick();
    checks++;
    if (flush_count !== 8'h00) begin
      failures++; $display("FAIL flush_wrap: got %h expected 00", flush_count);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_ctrl: got %b expected 0000", {stall_front, stall_back, bubble, flush});
    end
    tick();
    checks++;
    if ({stall_cycles, flush_count} !== 24'h0) begin
      failures++; $display("FAIL rst_mid_counts: got %h/%h expected 0000/00", stall_cycles, flush_count);
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({bubble, flush} !== 2'b00) begin
      failures++; $display("FAIL rst_mid_no_flush: got %b expected 00", {bubble, flush});
    end
    tick();
    checks++;
    if (flush_count !== 8'h00) begin
      failures++; $display("FAIL rst_mid_flush_count: got %0d expected 0", flush_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_mem_wait();
    test_redirect_in_wait();
    test_redirect_load_use();
    test_random();
    test_flush_wrap();
    test_reset_mid_wait();
    test_stall_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
